// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder standing in for a DDR controller local interface.
// Optional `AVL_RESP_RANDSTALL_EN: LFSR-driven 0..3 cycle stall after each command.
module avl_mem_responder #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned READ_LAT    = 3,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  output logic              local_init_done,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_write,
  input  logic              avl_read,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_burstbegin,
  output logic              avl_waitrequest_n,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              avl_readdatavalid,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count,
  output logic              proto_err
);

  localparam int unsigned DEPTH   = 1 << MEM_AW;
  localparam int unsigned INIT_W  = 16;
  localparam int unsigned STALL_W = 16;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STALL_W-1:0] stall_len_c;
  logic               init_done_d, wrq_n_d, proto_err_d;
  logic [31:0]        wr_count_d, rd_count_d;
  logic               wr_fire_c, rd_fire_c;
  logic [MEM_AW-1:0]  mem_idx_c;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [READ_LAT-1:0] pipe_vld_q;
  logic [DATA_W-1:0]  pipe_dat_q [READ_LAT];

  // Upper address bits alias onto the RAM; burstbegin carries no function here.
  logic unused_c;
  assign unused_c  = ^{avl_burstbegin, avl_address[ADDR_W-1:MEM_AW]};
  assign mem_idx_c = avl_address[MEM_AW-1:0];

`ifdef AVL_RESP_RANDSTALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall_len_c = STALL_W'(lfsr_q[1:0]);
`else
  assign stall_len_c = STALL_W'(WAIT_CYCLES);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    stall_cnt_d = stall_cnt_q;
    init_done_d = local_init_done;
    wrq_n_d     = avl_waitrequest_n;
    proto_err_d = proto_err;
    wr_count_d  = wr_count;
    rd_count_d  = rd_count;
    wr_fire_c   = 1'b0;
    rd_fire_c   = 1'b0;
    case (state_q)
      S_INIT: begin
        wrq_n_d = 1'b0;
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d     = S_READY;
          init_done_d = 1'b1;
          wrq_n_d     = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_READY: begin
        if (avl_waitrequest_n && (avl_write || avl_read)) begin
          if (avl_write && avl_read) begin
            proto_err_d = 1'b1;
          end else if (avl_write) begin
            wr_fire_c  = 1'b1;
            wr_count_d = wr_count + 32'd1;
          end else begin
            rd_fire_c  = 1'b1;
            rd_count_d = rd_count + 32'd1;
          end
          // A colliding request still takes the acceptance path, stall included
          if (stall_len_c != '0) begin
            state_d     = S_STALL;
            wrq_n_d     = 1'b0;
            stall_cnt_d = stall_len_c - STALL_W'(1);
          end
        end
      end
      S_STALL: begin
        if (stall_cnt_q == '0) begin
          state_d = S_READY;
          wrq_n_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q - STALL_W'(1);
        end
      end
      default: begin
        state_d = S_INIT;
        wrq_n_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q           <= S_INIT;
      init_cnt_q        <= '0;
      stall_cnt_q       <= '0;
      local_init_done   <= 1'b0;
      avl_waitrequest_n <= 1'b0;
      proto_err         <= 1'b0;
      wr_count          <= '0;
      rd_count          <= '0;
    end else begin
      state_q           <= state_d;
      init_cnt_q        <= init_cnt_d;
      stall_cnt_q       <= stall_cnt_d;
      local_init_done   <= init_done_d;
      avl_waitrequest_n <= wrq_n_d;
      proto_err         <= proto_err_d;
      wr_count          <= wr_count_d;
      rd_count          <= rd_count_d;
    end
  end

  // Backing RAM keeps its contents across reset
  always_ff @(posedge iCLK) begin
    if (wr_fire_c) mem[mem_idx_c] <= avl_writedata;
  end

  // Read latency pipeline; the last stage is the registered response
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pipe_vld_q <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) pipe_dat_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_fire_c;
      if (rd_fire_c) pipe_dat_q[0] <= mem[mem_idx_c];
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  assign avl_readdatavalid = pipe_vld_q[READ_LAT-1];
  assign avl_readdata      = pipe_dat_q[READ_LAT-1];

endmodule

// File: tb/tb_avl_mem_responder.sv
// Bench for avl_mem_responder: a stalling (WAIT_CYCLES=1) and a non-stalling instance
// share stimulus and are compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_avl_mem_responder;
  localparam int unsigned ADDR_W      = 27;
  localparam int unsigned MEM_AW      = 10;
  localparam int unsigned READ_LAT    = 3;
  localparam int unsigned INIT_CYCLES = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] address;
  logic              wr, rd, burst;
  logic [31:0]       wdata;

  logic        dn [2];
  logic        wrq [2];
  logic        rdv [2];
  logic        perr [2];
  logic [31:0] rdat [2];
  logic [31:0] wcnt [2];
  logic [31:0] rcnt [2];

  avl_mem_responder #(.WAIT_CYCLES(1), .READ_LAT(READ_LAT), .INIT_CYCLES(INIT_CYCLES)) u_slow (
    .iCLK(clk), .iRST_n(rst_n), .local_init_done(dn[0]), .avl_address(address),
    .avl_write(wr), .avl_read(rd), .avl_writedata(wdata), .avl_burstbegin(burst),
    .avl_waitrequest_n(wrq[0]), .avl_readdata(rdat[0]), .avl_readdatavalid(rdv[0]),
    .wr_count(wcnt[0]), .rd_count(rcnt[0]), .proto_err(perr[0]));

  avl_mem_responder #(.WAIT_CYCLES(0), .READ_LAT(READ_LAT), .INIT_CYCLES(INIT_CYCLES)) u_fast (
    .iCLK(clk), .iRST_n(rst_n), .local_init_done(dn[1]), .avl_address(address),
    .avl_write(wr), .avl_read(rd), .avl_writedata(wdata), .avl_burstbegin(burst),
    .avl_waitrequest_n(wrq[1]), .avl_readdata(rdat[1]), .avl_readdatavalid(rdv[1]),
    .wr_count(wcnt[1]), .rd_count(rcnt[1]), .proto_err(perr[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = stalling instance, 1 = non-stalling instance
  int          e;
  bit          m_init;
  bit          m_ready [2];
  int          m_stall [2];
  logic [31:0] m_wc [2];
  logic [31:0] m_rc [2];
  bit          m_perr [2];
  logic [31:0] m_mem [2][1024];
  bit          m_known [2][1024];
  bit          m_pv [2][16];
  logic [31:0] m_pd [2][16];
  bit          m_pk [2][16];
  bit          x_rdv [2];
  logic [31:0] x_rd [2];
  bit          x_rk [2];
  bit          acc [2];

  typedef struct {
    bit          w;
    bit          r;
    logic [26:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [18];

  typedef struct {
    bit          w;
    bit          r;
    logic [26:0] a;
    logic [31:0] d;
    bit          ev;
    logic [31:0] ed;
  } seq_t;
  seq_t seq3 [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e      = 0;
    m_init = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ready[i] = 1'b0; m_stall[i] = 0; m_wc[i] = '0; m_rc[i] = '0; m_perr[i] = 1'b0;
      x_rdv[i] = 1'b0; x_rd[i] = '0; x_rk[i] = 1'b1; acc[i] = 1'b0;
      for (int j = 0; j < 16; j++) m_pv[i][j] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit was_init;
    int slot;
    int w;
    int idx;
    if (!rst_n) return;
    e++;
    was_init = m_init;
    if (!m_init && e == int'(INIT_CYCLES)) begin
      m_init = 1'b1; m_ready[0] = 1'b1; m_ready[1] = 1'b1;
    end
    idx = int'(address[MEM_AW-1:0]);
    for (int i = 0; i < 2; i++) begin
      w      = (i == 0) ? 1 : 0;
      acc[i] = 1'b0;
      if (was_init && m_ready[i]) begin
        if (wr || rd) begin
          acc[i] = 1'b1;
          if (wr && rd) m_perr[i] = 1'b1;
          else if (wr) begin
            m_mem[i][idx] = wdata; m_known[i][idx] = 1'b1; m_wc[i] = m_wc[i] + 32'd1;
          end else begin
            slot = (e + int'(READ_LAT) - 1) % 16;
            m_pv[i][slot] = 1'b1; m_pd[i][slot] = m_mem[i][idx]; m_pk[i][slot] = m_known[i][idx];
            m_rc[i] = m_rc[i] + 32'd1;
          end
          if (w > 0) begin m_ready[i] = 1'b0; m_stall[i] = w; end
        end
      end else if (was_init) begin
        m_stall[i]--;
        if (m_stall[i] == 0) m_ready[i] = 1'b1;
      end
      slot     = e % 16;
      x_rdv[i] = m_pv[i][slot];
      if (m_pv[i][slot]) begin
        x_rd[i] = m_pd[i][slot]; x_rk[i] = m_pk[i][slot]; m_pv[i][slot] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string n;
      n = (i == 0) ? "slow" : "fast";
      chk({n, ".init_done"}, 32'(dn[i]), 32'(m_init));
      chk({n, ".waitrequest_n"}, 32'(wrq[i]), 32'(m_init && m_ready[i]));
      chk({n, ".readdatavalid"}, 32'(rdv[i]), 32'(x_rdv[i]));
      if (x_rk[i]) chk({n, ".readdata"}, rdat[i], x_rd[i]);
      chk({n, ".wr_count"}, wcnt[i], m_wc[i]);
      chk({n, ".rd_count"}, rcnt[i], m_rc[i]);
      chk({n, ".proto_err"}, 32'(perr[i]), 32'(m_perr[i]));
    end
  endtask

  // Inputs are applied at a falling edge; one call spans one rising edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; burst = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (INIT_CYCLES) step();
  endtask

  // Hold a command until the stalling instance takes it; for reads check latency and data.
  task automatic do_cmd(input bit w, input bit r, input logic [26:0] a, input logic [31:0] d,
                        input logic [31:0] exp);
    int n;
    bit got;
    wr = w; rd = r; address = a; wdata = d; burst = 1'b1;
    got = 1'b0;
    for (n = 0; n < 20 && !got; n++) begin
      step();
      got   = acc[0];
      burst = 1'b0;
    end
    wr = 1'b0; rd = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    else if (r && !w) begin
      n = 0;
      while (!rdv[0] && n < 10) begin step(); n++; end
      chk("read_latency", 32'(n), 32'(READ_LAT - 1));
      chk("read_data", rdat[0], exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    logic [26:0] a;
    bit lv [9];
    logic [31:0] ld [9];

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b1, 1'b0, 27'(i), 32'hAA55AA55, 32'h0};
      tbl[8 + i] = '{1'b0, 1'b1, 27'(i), 32'h0, 32'hAA55AA55};
    end
    tbl[16] = '{1'b1, 1'b0, 27'h400, 32'hDEADBEEF, 32'h0};
    tbl[17] = '{1'b0, 1'b1, 27'h000, 32'h0, 32'hDEADBEEF};

    seq3[0] = '{1'b1, 1'b0, 27'd6, 32'h66666666, 1'b0, 32'h0};
    seq3[1] = '{1'b1, 1'b0, 27'd7, 32'h77777777, 1'b0, 32'h0};
    seq3[2] = '{1'b1, 1'b0, 27'd5, 32'h12345678, 1'b0, 32'h0};
    seq3[3] = '{1'b0, 1'b1, 27'd5, 32'h0, 1'b0, 32'h0};
    seq3[4] = '{1'b0, 1'b1, 27'd6, 32'h0, 1'b0, 32'h0};
    seq3[5] = '{1'b0, 1'b1, 27'd7, 32'h0, 1'b1, 32'h12345678};
    seq3[6] = '{1'b0, 1'b0, 27'd0, 32'h0, 1'b1, 32'h66666666};
    seq3[7] = '{1'b0, 1'b0, 27'd0, 32'h0, 1'b1, 32'h77777777};
    seq3[8] = '{1'b0, 1'b0, 27'd0, 32'h0, 1'b0, 32'h0};

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) m_known[i][j] = 1'b0;

    rst_n = 1'b1; address = '0; wdata = '0; idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all();

    // Init window: a write held from edge 3 waits for edge 17
    rst_n = 1'b1;
    step(); step();
    wr = 1'b1; address = 27'd100; wdata = 32'h11;
    repeat (13) step();
    chk("p1.init_before", 32'(dn[0]), 32'd0);
    chk("p1.wrcnt_before", wcnt[0], 32'd0);
    step();
    chk("p1.init_at16", 32'(dn[0]), 32'd1);
    chk("p1.wrq_at16", 32'(wrq[0]), 32'd1);
    chk("p1.wrcnt_at16", wcnt[0], 32'd0);
    step();
    chk("p1.wrcnt_accepted", wcnt[0], 32'd1);
    idle();

    do_reset();

    for (int i = 0; i < 16; i++) do_cmd(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp);
    chk("p2.wr_count", wcnt[0], 32'd8);
    chk("p2.rd_count", rcnt[0], 32'd8);
    for (int i = 16; i < 18; i++) do_cmd(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp);

    // Colliding read+write
    do_cmd(1'b1, 1'b1, 27'd3, 32'h0BADF00D, 32'h0);
    step();
    chk("p5.proto_err", 32'(perr[0]), 32'd1);
    chk("p5.wr_count", wcnt[0], 32'd9);
    chk("p5.rd_count", rcnt[0], 32'd9);
    do_cmd(1'b0, 1'b1, 27'd3, 32'h0, 32'hAA55AA55);
    repeat (4) step();
    chk("p5.proto_err_sticky", 32'(perr[0]), 32'd1);

    // Back-to-back traffic on the non-stalling instance
    idle();
    repeat (3) step();
    for (int k = 0; k < 9; k++) begin
      wr = seq3[k].w; rd = seq3[k].r; address = seq3[k].a; wdata = seq3[k].d;
      step();
      lv[k] = rdv[1]; ld[k] = rdat[1];
    end
    idle();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("p3.valid%0d", k), 32'(lv[k]), 32'(seq3[k].ev));
      if (seq3[k].ev) chk($sformatf("p3.data%0d", k), ld[k], seq3[k].ed);
    end

    // Random traffic with aliased addresses
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 99));
      a = 27'($urandom);
      a[9:4] = '0;
      wr = (r < 35) || (r == 99);
      rd = (r >= 35 && r < 70) || (r == 99);
      address = a; wdata = $urandom; burst = 1'($urandom_range(0, 1));
      step();
    end
    idle();
    repeat (4) step();

    // Reset one cycle after a read is accepted
    do_cmd(1'b1, 1'b0, 27'd9, 32'hCAFEF00D, 32'h0);
    repeat (3) step();
    rd = 1'b1; address = 27'd9;
    for (n = 0; n < 20 && !acc[0]; n++) step();
    rd = 1'b0;
    chk("p6.accept", 32'(acc[0]), 32'd1);
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("p6.init_drop_slow", 32'(dn[0]), 32'd0);
    chk("p6.init_drop_fast", 32'(dn[1]), 32'd0);
    chk("p6.rdv_cleared", 32'(rdv[0]), 32'd0);
    chk("p6.wrq_cleared", 32'(wrq[0]), 32'd0);
    @(negedge clk);
    check_all();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (INIT_CYCLES) step();
    chk("p6.reinit", 32'(dn[0]), 32'd1);
    do_cmd(1'b0, 1'b1, 27'd9, 32'h0, 32'hCAFEF00D);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
